// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of an async FIFO write port.
// NREQ valid/ready requesters share winc/wdata. Each grant moves up to BURST
// words. Every write is gated by wfull. One idle cycle separates grants.
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  gnt_active
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [IW-1:0]     rr_last_reg, rr_last_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  logic [DSIZE-1:0]  slice [NREQ];
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              cur_valid;
  logic              xfer;
  logic              last_word;

  // Unpack the flattened requester data bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slice[gi] = req_data[gi*DSIZE +: DSIZE];
  end

  // Round-robin pick: first valid index after the last granted one, wrapping.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_last_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // A word moves only while granted, the owner is valid and the FIFO has room.
  assign cur_valid = req_valid[idx_reg];
  assign xfer      = (state_reg == GRANT) && cur_valid && !wfull;
  assign last_word = (cnt_reg == CNT_LAST);

  // Next-state: grant from IDLE, count words in GRANT, release on burst end
  // or when the owner drops valid. A full FIFO only stalls, never releases.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    idx_next     = idx_reg;
    rr_last_next = rr_last_reg;
    cnt_next     = cnt_reg;
    if (state_reg == IDLE) begin
      if (pick_found) begin
        state_next         = GRANT;
        gnt_next           = '0;
        gnt_next[pick_idx] = 1'b1;
        idx_next           = pick_idx;
        cnt_next           = '0;
      end
    end else begin
      if (!cur_valid || (xfer && last_word)) begin
        state_next   = IDLE;
        gnt_next     = '0;
        cnt_next     = '0;
        rr_last_next = idx_reg;
      end else if (xfer) begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  // Outputs: write strobe, data mux and ready all follow the registered grant.
  always_comb begin
    req_ready  = '0;
    winc       = xfer;
    wdata      = '0;
    gnt        = gnt_reg;
    gnt_active = (state_reg == GRANT);
    if (state_reg == GRANT) begin
      req_ready[idx_reg] = !wfull;
      wdata              = slice[idx_reg];
    end
  end

  // State register; reset makes requester 0 the first winner.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      idx_reg     <= '0;
      rr_last_reg <= IDX_LAST;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      idx_reg     <= idx_next;
      rr_last_reg <= rr_last_next;
      cnt_reg     <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: requester queues, a write-side scoreboard,
// and a small behavioural FIFO for the integration scenario.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int DSIZE  = 8;
  localparam int NREQ   = 4;
  localparam int BURST  = 4;
  localparam int MDEPTH = 128;
  localparam int FDEPTH = 8;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [NREQ-1:0]       gnt;
  logic                  gnt_active;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt(gnt), .gnt_active(gnt_active)
  );

  always #5 wclk = ~wclk;

  int vectors = 0;
  int miscompares = 0;

  // Requester sources and the expected-write scoreboard per requester
  logic [DSIZE-1:0] src_mem [NREQ][MDEPTH];
  logic [DSIZE-1:0] exp_mem [NREQ][MDEPTH];
  int               src_wr [NREQ];
  int               src_rd [NREQ];
  int               exp_wr [NREQ];
  int               exp_rd [NREQ];
  logic [NREQ-1:0]  en;

  // Behavioural FIFO for integration
  bit               fifo_mode;
  logic [DSIZE-1:0] fifo_q [$];
  bit               last_rd_valid;
  logic [DSIZE-1:0] last_rd_word;

  // Requester protocol tracking
  logic [NREQ-1:0]  prev_hold = '0;
  logic [DSIZE-1:0] prev_data [NREQ];

  function automatic int ohidx(input logic [NREQ-1:0] v);
    ohidx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) ohidx = i;
  endfunction

  function automatic bit all_empty();
    all_empty = 1'b1;
    for (int i = 0; i < NREQ; i++) if (src_rd[i] != src_wr[i]) all_empty = 1'b0;
  endfunction

  task automatic push_word(input int i, input logic [DSIZE-1:0] w);
    src_mem[i][src_wr[i]] = w;
    src_wr[i]++;
    exp_mem[i][exp_wr[i]] = w;
    exp_wr[i]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (src_rd[i] != src_wr[i]);
      req_data[i*DSIZE +: DSIZE] = req_valid[i] ? src_mem[i][src_rd[i]] : '0;
    end
  endtask

  // One clock: sample handshakes at negedge, update sources/FIFO after posedge
  task automatic tick(input logic wf);
    logic [NREQ-1:0]  hs;
    logic             wr_s;
    logic [DSIZE-1:0] wd_s;
    bit               rd_s;
    @(negedge wclk);
    hs   = req_valid & req_ready;
    wr_s = winc;
    wd_s = wdata;
    rd_s = fifo_mode && (fifo_q.size() > 0) && ($urandom_range(0, 99) < 45);
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) src_rd[i]++;
    last_rd_valid = 1'b0;
    if (rd_s) begin
      last_rd_word  = fifo_q.pop_front();
      last_rd_valid = 1'b1;
    end
    if (fifo_mode && wr_s) fifo_q.push_back(wd_s);
    wfull = fifo_mode ? (fifo_q.size() >= FDEPTH) : wf;
    drive_inputs();
    #1;
  endtask

  task automatic drain(output bit ok, output int pend);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (all_empty() && !gnt_active) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0);
    end
    pend = 0;
    for (int i = 0; i < NREQ; i++) pend += exp_wr[i] - exp_rd[i];
  endtask

  task automatic do_reset();
    wrst_n    = 1'b0;
    fifo_mode = 1'b0;
    wfull     = 1'b0;
    en        = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
    end
    fifo_q.delete();
    last_rd_valid = 1'b0;
    drive_inputs();
    repeat (2) @(posedge wclk);
    #2 wrst_n = 1'b1;
  endtask

  // Write-side monitor: pop the expected word for the granted requester on winc
  always @(negedge wclk) begin : mon
    int g;
    if (wrst_n === 1'b1) begin
      if (winc && wfull) begin
        miscompares++;
        $display("FAIL winc_while_full: winc=%b wfull=%b, required winc=0", winc, wfull);
      end
      if (winc) begin
        vectors++;
        g = ohidx(gnt);
        if ($countones(gnt) != 1) begin
          miscompares++;
          $display("FAIL write_grant: gnt=%b on write, required one-hot", gnt);
        end else if (exp_rd[g] >= exp_wr[g]) begin
          miscompares++;
          $display("FAIL write_extra: req %0d wrote %h, required no further word", g, wdata);
        end else begin
          if (wdata !== exp_mem[g][exp_rd[g]]) begin
            miscompares++;
            $display("FAIL write_data: req %0d wdata=%h, required %h", g, wdata, exp_mem[g][exp_rd[g]]);
          end
          exp_rd[g]++;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (prev_hold[i] && req_valid[i] && (req_data[i*DSIZE +: DSIZE] !== prev_data[i])) begin
        miscompares++;
        $display("FAIL req_protocol: req %0d data=%h changed while stalled, required %h",
                 i, req_data[i*DSIZE +: DSIZE], prev_data[i]);
      end
      prev_hold[i] = req_valid[i] && !req_ready[i];
      prev_data[i] = req_data[i*DSIZE +: DSIZE];
    end
  end

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    en     = '1;
    for (int i = 0; i < NREQ; i++) push_word(i, 8'hA0 + 8'(i));
    drive_inputs();
    repeat (2) @(negedge wclk);
    vectors++;
    if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: gnt=%b, required 0000", gnt); end
    vectors++;
    if (winc !== 1'b0) begin miscompares++; $display("FAIL reset_winc: winc=%b, required 0", winc); end
    vectors++;
    if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready); end
    vectors++;
    if (wdata !== '0) begin miscompares++; $display("FAIL reset_wdata: wdata=%h, required 00", wdata); end
    vectors++;
    if (gnt_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: gnt_active=%b, required 0", gnt_active); end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] exp_g [6];
    logic            exp_w [6];
    bit              ok;
    int              pend;
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 8; k++) push_word(0, 8'h10 + 8'(k));
    en = 4'b0001;
    drive_inputs();
    for (int c = 0; c < 6; c++) begin
      tick(1'b0);
      vectors++;
      if (gnt !== exp_g[c] || winc !== exp_w[c]) begin
        miscompares++;
        $display("FAIL single_burst cycle %0d: gnt=%b winc=%b, required gnt=%b winc=%b",
                 c + 1, gnt, winc, exp_g[c], exp_w[c]);
      end
    end
    drain(ok, pend);
    vectors++;
    if (!ok || pend != 0) begin
      miscompares++;
      $display("FAIL single_drain: done=%0d pending=%0d, required done=1 pending=0", ok, pend);
    end
  endtask

  task automatic test_round_robin();
    int   seq [$];
    int   exp_seq [5];
    int   wcount;
    int   idle;
    logic prev_act;
    bit   ok;
    int   pend;
    exp_seq = '{0, 1, 2, 3, 0};
    wcount = 0; idle = 0; prev_act = 1'b0;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) push_word(i, 8'((i << 4) | k));
    en = '1;
    drive_inputs();
    for (int c = 0; c < 25; c++) begin
      tick(1'b0);
      if (gnt_active && !prev_act) seq.push_back(ohidx(gnt));
      if (winc) wcount++;
      if (!gnt_active) idle++;
      prev_act = gnt_active;
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (k >= seq.size() || seq[k] != exp_seq[k]) begin
        miscompares++;
        $display("FAIL rr_order grant %0d: req=%0d, required %0d",
                 k, (k < seq.size()) ? seq[k] : -1, exp_seq[k]);
      end
    end
    vectors++;
    if (wcount != 20) begin miscompares++; $display("FAIL rr_duty: writes=%0d in 25 cycles, required 20", wcount); end
    vectors++;
    if (idle != 5) begin miscompares++; $display("FAIL rr_bubbles: idle cycles=%0d, required 5", idle); end
    drain(ok, pend);
    vectors++;
    if (!ok || pend != 0) begin
      miscompares++;
      $display("FAIL rr_drain: done=%0d pending=%0d, required done=1 pending=0", ok, pend);
    end
  endtask

  task automatic test_stall();
    logic            wf [8];
    logic            exp_w [8];
    logic [NREQ-1:0] exp_r [8];
    logic [NREQ-1:0] exp_g [8];
    bit              ok;
    int              pend;
    wf    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_r = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    do_reset();
    for (int k = 0; k < 6; k++) push_word(0, 8'h30 + 8'(k));
    en = 4'b0001;
    drive_inputs();
    for (int c = 0; c < 8; c++) begin
      tick(wf[c]);
      vectors++;
      if (winc !== exp_w[c] || req_ready !== exp_r[c] || gnt !== exp_g[c]) begin
        miscompares++;
        $display("FAIL stall cycle %0d: winc=%b ready=%b gnt=%b, required winc=%b ready=%b gnt=%b",
                 c + 1, winc, req_ready, gnt, exp_w[c], exp_r[c], exp_g[c]);
      end
    end
    drain(ok, pend);
    vectors++;
    if (!ok || pend != 0) begin
      miscompares++;
      $display("FAIL stall_drain: done=%0d pending=%0d, required done=1 pending=0", ok, pend);
    end
  endtask

  task automatic test_drop();
    logic [NREQ-1:0] exp_g [5];
    logic            exp_w [5];
    bit              ok;
    int              pend;
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    exp_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 2; k++) push_word(1, 8'h50 + 8'(k));
    for (int k = 0; k < 4; k++) push_word(2, 8'h60 + 8'(k));
    en = 4'b0110;
    drive_inputs();
    for (int c = 0; c < 5; c++) begin
      tick(1'b0);
      vectors++;
      if (gnt !== exp_g[c] || winc !== exp_w[c]) begin
        miscompares++;
        $display("FAIL drop cycle %0d: gnt=%b winc=%b, required gnt=%b winc=%b",
                 c + 1, gnt, winc, exp_g[c], exp_w[c]);
      end
    end
    drain(ok, pend);
    vectors++;
    if (!ok || pend != 0) begin
      miscompares++;
      $display("FAIL drop_drain: done=%0d pending=%0d, required done=1 pending=0", ok, pend);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int pend;
    do_reset();
    for (int k = 0; k < 8; k++) push_word(2, 8'h70 + 8'(k));
    en = 4'b0100;
    drive_inputs();
    for (int c = 0; c < 2; c++) begin
      tick(1'b0);
      vectors++;
      if (gnt !== 4'b0100 || winc !== 1'b1) begin
        miscompares++;
        $display("FAIL areset_pre cycle %0d: gnt=%b winc=%b, required gnt=0100 winc=1", c + 1, gnt, winc);
      end
    end
    #1 wrst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== '0 || winc !== 1'b0 || req_ready !== '0 || gnt_active !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_async: gnt=%b winc=%b ready=%b active=%b, required all 0",
               gnt, winc, req_ready, gnt_active);
    end
    for (int k = 0; k < 2; k++) push_word(0, 8'h80 + 8'(k));
    for (int k = 0; k < 2; k++) push_word(3, 8'h90 + 8'(k));
    en = 4'b1101;
    drive_inputs();
    @(posedge wclk);
    #2 wrst_n = 1'b1;
    tick(1'b0);
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL areset_first: gnt=%b, required 0001", gnt);
    end
    drain(ok, pend);
    vectors++;
    if (!ok || pend != 0) begin
      miscompares++;
      $display("FAIL areset_drain: done=%0d pending=%0d, required done=1 pending=0", ok, pend);
    end
  endtask

  task automatic test_fifo_integration();
    int rx_seq [NREQ];
    int rx_total;
    int tag;
    int sq;
    do_reset();
    fifo_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rx_seq[i] = 0;
      for (int k = 0; k < 64; k++) push_word(i, 8'((i << 6) | k));
    end
    rx_total = 0;
    en = '1;
    drive_inputs();
    for (int n = 0; n < 4000; n++) begin
      tick(1'b0);
      if (last_rd_valid) begin
        tag = int'(last_rd_word) >> 6;
        sq  = int'(last_rd_word) & 63;
        vectors++;
        if (sq != rx_seq[tag]) begin
          miscompares++;
          $display("FAIL fifo_order: req %0d seq=%0d, required %0d", tag, sq, rx_seq[tag]);
        end
        rx_seq[tag]++;
        rx_total++;
      end
      if (rx_total >= 256) break;
    end
    vectors++;
    if (rx_total != 256) begin
      miscompares++;
      $display("FAIL fifo_total: received=%0d, required 256", rx_total);
    end
    for (int i = 0; i < NREQ; i++) begin
      vectors++;
      if (rx_seq[i] != 64) begin
        miscompares++;
        $display("FAIL fifo_count: req %0d received=%0d, required 64", i, rx_seq[i]);
      end
    end
    fifo_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_async_reset();
    test_fifo_integration();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
